// File: rtl/dispatch4way16_pkg.sv
// Shared constants, FIFO entry layout and lane decode helper for dispatch4way16.
// The `define constants are visible to every file compiled after this one.
`ifndef DISPATCH4WAY16_DEFS
`define DISPATCH4WAY16_DEFS
`define D4W16_WIDTH 16
`define D4W16_LANES 4
`define D4W16_DEPTH 2
`define D4W16_SEL_W 2
`endif

package dispatch4way16_pkg;

  localparam int unsigned WIDTH   = `D4W16_WIDTH;
  localparam int unsigned LANES   = `D4W16_LANES;
  localparam int unsigned DEPTH   = `D4W16_DEPTH;
  localparam int unsigned SEL_W   = `D4W16_SEL_W;
  localparam int unsigned ENTRY_W = WIDTH + SEL_W;

  typedef struct packed {
    logic [SEL_W-1:0] lane;
    logic [WIDTH-1:0] data;
  } entry_t;

  function automatic logic [LANES-1:0] lane_onehot(input logic [SEL_W-1:0] sel);
    logic [LANES-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/dispatch4way16_fifo2x16.sv
// fifo2x16: 2-entry FIFO of 18-bit entries (lane tag + data) with 1-bit pointers.
// The head is forced to zero when empty so downstream decode needs no extra gating.
module fifo2x16
  import dispatch4way16_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] wr_entry,
  output logic [ENTRY_W-1:0] head,
  output logic [1:0]         count
);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic               wr_ptr;
  logic               rd_ptr;
  logic               do_push;
  logic               do_pop;

  always_comb begin
    do_push = push && (count != 2'(DEPTH));
    do_pop  = pop && (count != 2'd0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    head = (count != 2'd0) ? mem[rd_ptr] : '0;
  end

endmodule

// File: rtl/dispatch4way16.sv
// Four-lane 16-bit dispatcher: buffers words in a 2-entry FIFO, tags each with a lane,
// presents the head with a one-hot per-lane valid. Optional macro: DISPATCH_ADDR_EN.
module dispatch4way16
  import dispatch4way16_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] in_data,
  input  logic [1:0]  in_lane,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic [1:0]  out_sel,
  output logic [3:0]  out_valid,
  input  logic [3:0]  out_ready,
  output logic [1:0]  count
);

  logic               push;
  logic               pop;
  logic [SEL_W-1:0]   tag;
  logic [ENTRY_W-1:0] head;
  entry_t             head_entry;
  entry_t             wr_entry;

`ifdef DISPATCH_ADDR_EN
  always_comb begin
    tag = in_lane;
  end
`else
  logic [SEL_W-1:0] rr;
  logic             unused_in_lane;

  always_comb begin
    tag            = rr;
    unused_in_lane = ^in_lane;
  end

  // Advances only on an accepted push; pops and refused pushes leave it alone.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr <= '0;
    end else if (push) begin
      rr <= rr + 1'b1;
    end
  end
`endif

  always_comb begin
    in_ready      = (count != 2'(DEPTH));
    push          = in_valid && in_ready;
    wr_entry.data = in_data;
    wr_entry.lane = tag;
    head_entry    = entry_t'(head);
    out_data      = head_entry.data;
    out_sel       = head_entry.lane;
    out_valid     = (count != 2'd0) ? lane_onehot(head_entry.lane) : '0;
    pop           = |(out_valid & out_ready);
  end

  fifo2x16 u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (push),
    .pop      (pop),
    .wr_entry (wr_entry),
    .head     (head),
    .count    (count)
  );

endmodule

// File: tb/tb_dispatch4way16.sv
// Directed self-checking bench for dispatch4way16 with hand-computed expectations.
module tb_dispatch4way16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] in_data = '0;
  logic [1:0]  in_lane = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic [1:0]  out_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = '0;
  logic [1:0]  count;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  always #5 clock = ~clock;

  dispatch4way16 dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_lane   (in_lane),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // In the default build in_lane is driven with the wrong lane so any leak shows up.
  task automatic offer(input logic [15:0] data, input logic [1:0] lane);
    in_valid = 1'b1;
    in_data  = data;
`ifdef DISPATCH_ADDR_EN
    in_lane  = lane;
`else
    in_lane  = ~lane;
`endif
  endtask

  task automatic expect_state(input string tag, input logic [1:0] cnt, input logic [15:0] data,
                              input logic [1:0] sel, input logic [3:0] vld);
    check({tag, ".count"}, 32'(count), 32'(cnt));
    check({tag, ".in_ready"}, 32'(in_ready), 32'(cnt != 2'd2));
    check({tag, ".out_data"}, 32'(out_data), 32'(data));
    check({tag, ".out_sel"}, 32'(out_sel), 32'(sel));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(vld));
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = '0;
    reset_n   = 1'b0;
    #2;
    reset_n   = 1'b1;
  endtask

  initial begin
    #12;
    expect_state("reset", 2'd0, 16'h0000, 2'd0, 4'b0000);
    reset_n = 1'b1;

    // Round-robin tagging at full throughput
    out_ready = 4'b1111;
    offer(16'hA000, 2'd0); tick(); expect_state("rr0", 2'd1, 16'hA000, 2'd0, 4'b0001);
    offer(16'hA001, 2'd1); tick(); expect_state("rr1", 2'd1, 16'hA001, 2'd1, 4'b0010);
    offer(16'hA002, 2'd2); tick(); expect_state("rr2", 2'd1, 16'hA002, 2'd2, 4'b0100);
    offer(16'hA003, 2'd3); tick(); expect_state("rr3", 2'd1, 16'hA003, 2'd3, 4'b1000);
    offer(16'hA004, 2'd0); tick(); expect_state("rr4", 2'd1, 16'hA004, 2'd0, 4'b0001);
    in_valid = 1'b0;       tick(); expect_state("rr_drain", 2'd0, 16'h0000, 2'd0, 4'b0000);

    // Lane 0 stalled: fill, refuse a third push, then release
    do_reset();
    out_ready = 4'b1110;
    offer(16'h1111, 2'd0); tick(); expect_state("stall1", 2'd1, 16'h1111, 2'd0, 4'b0001);
    offer(16'h2222, 2'd1); tick(); expect_state("stall2", 2'd2, 16'h1111, 2'd0, 4'b0001);
    offer(16'h3333, 2'd2); tick(); expect_state("full_refuse", 2'd2, 16'h1111, 2'd0, 4'b0001);
    out_ready = 4'b1111;   tick(); expect_state("pop_at_full", 2'd1, 16'h2222, 2'd1, 4'b0010);
    tick(); expect_state("push_pop_c1", 2'd1, 16'h3333, 2'd2, 4'b0100);
    in_valid = 1'b0; tick(); expect_state("stall_drain", 2'd0, 16'h0000, 2'd0, 4'b0000);

    // Ready on the wrong lanes must not pop
    out_ready = 4'b0111;
    offer(16'h4444, 2'd3); tick(); expect_state("wrong_rdy1", 2'd1, 16'h4444, 2'd3, 4'b1000);
    in_valid = 1'b0;       tick(); expect_state("wrong_rdy2", 2'd1, 16'h4444, 2'd3, 4'b1000);
    out_ready = 4'b1000;   tick(); expect_state("lane3_pop", 2'd0, 16'h0000, 2'd0, 4'b0000);

    // Asynchronous reset while full, checked before any clock edge
    out_ready = 4'b0000;
    offer(16'h5555, 2'd0); tick();
    offer(16'h6666, 2'd1); tick(); expect_state("pre_areset", 2'd2, 16'h5555, 2'd0, 4'b0001);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1 expect_state("async_reset", 2'd0, 16'h0000, 2'd0, 4'b0000);
    reset_n = 1'b1;
    offer(16'h7777, 2'd0); tick(); expect_state("post_reset", 2'd1, 16'h7777, 2'd0, 4'b0001);
    in_valid = 1'b0;

`ifdef DISPATCH_ADDR_EN
    do_reset();
    out_ready = 4'b0111;
    offer(16'hBEEF, 2'd3); tick(); expect_state("addr1", 2'd1, 16'hBEEF, 2'd3, 4'b1000);
    offer(16'hCAFE, 2'd3); tick(); expect_state("addr2", 2'd2, 16'hBEEF, 2'd3, 4'b1000);
    in_valid = 1'b0;       tick(); expect_state("addr_hold", 2'd2, 16'hBEEF, 2'd3, 4'b1000);
    out_ready = 4'b1000;   tick(); expect_state("addr_pop1", 2'd1, 16'hCAFE, 2'd3, 4'b1000);
    tick(); expect_state("addr_pop2", 2'd0, 16'h0000, 2'd0, 4'b0000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
